serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder that sits directly upstream of the team's one-bit full-adder cell. It accepts two parallel operands and a carry-in, feeds one bit pair per clock through a single full-adder cell with a registered carry, and reassembles the parallel sum. Area is traded for latency: one adder cell instead of WIDTH cells. A start/busy/done handshake controls it.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fa_bit.sv | 13 +
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder slice.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_bit.sv
// One-bit full-adder cell; the serial adder time-multiplexes a single instance.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (y & ci) | (x & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a registered carry and
// shift registers that reassemble the parallel sum over WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             cf_q, cf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;

  fa_bit u_fa (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .ci (cf_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    cf_d    = cf_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cf_d    = c_in;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sr_d  = {fa_s, sr_q[WIDTH-1:1]};
        cf_d  = fa_co;
        cnt_d = cnt_q + CW'(1);
        // The final bit bypasses sr so the result lands on the same edge.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, sr_q[WIDTH-1:1]};
          carry_d = fa_co;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      sr_q    <= {WIDTH{1'b0}};
      cf_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      cf_q    <= cf_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 (unit 0) and WIDTH=2 (unit 1).
module tb_serial_adder;

  typedef struct {
    int val;
    int acc;
    int due;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       st0, ci0, busy0, done0, carry0;
  logic [7:0] a0, b0, sum0;
  logic       st1, ci1, busy1, done1, carry1;
  logic [1:0] a1, b1, sum1;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  last0 = 0;
  int  last1 = 0;
  sb_t q0[$];
  sb_t q1[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0), .c_in(ci0),
    .busy(busy0), .done(done0), .sum(sum0), .carry(carry0)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int width_of(input int u);
    return (u == 0) ? 8 : 2;
  endfunction

  function automatic int res(input int u);
    return (u == 0) ? int'({carry0, sum0}) : int'({carry1, sum1});
  endfunction

  function automatic logic get_done(input int u);
    return (u == 0) ? done0 : done1;
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 0) ? busy0 : busy1;
  endfunction

  function automatic int q_size(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic sb_t q_front(input int u);
    return (u == 0) ? q0[0] : q1[0];
  endfunction

  function automatic sb_t q_pop(input int u);
    if (u == 0) return q0.pop_front();
    else return q1.pop_front();
  endfunction

  // Drive one start pulse at the current negedge; returns at the next negedge.
  task automatic issue(input int u, input int a, input int b, input int ci, input bit accept);
    sb_t e;
    if (u == 0) begin
      a0 = 8'(a); b0 = 8'(b); ci0 = 1'(ci); st0 = 1'b1;
    end else begin
      a1 = 2'(a); b1 = 2'(b); ci1 = 1'(ci); st1 = 1'b1;
    end
    if (accept) begin
      e.val = a + b + ci;
      e.acc = cyc + 1;
      e.due = cyc + 1 + width_of(u);
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(negedge clk);
    if (u == 0) begin
      st0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom); ci0 = 1'($urandom);
    end else begin
      st1 = 1'b0; a1 = 2'($urandom); b1 = 2'($urandom); ci1 = 1'($urandom);
    end
  endtask

  task automatic wait_done(input int u);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = get_done(u);
    end
    if (!seen) check($sformatf("u%0d_done_timeout", u), 0, 1);
  endtask

  task automatic mon(input int u);
    sb_t e;
    int  exp_busy;
    if (rst) begin
      if (u == 0) begin q0.delete(); last0 = 0; end
      else begin q1.delete(); last1 = 0; end
      return;
    end
    if (get_done(u)) begin
      if (q_size(u) == 0) begin
        check($sformatf("u%0d_unexpected_done", u), 1, 0);
      end else begin
        e = q_pop(u);
        check($sformatf("u%0d_latency", u), cyc, e.due);
        check($sformatf("u%0d_result", u), res(u), e.val);
      end
      if (u == 0) last0 = res(u);
      else last1 = res(u);
    end else begin
      if (q_size(u) > 0 && cyc > q_front(u).due) begin
        check($sformatf("u%0d_done_missing", u), 0, 1);
        void'(q_pop(u));
      end
      check($sformatf("u%0d_hold", u), res(u), (u == 0) ? last0 : last1);
    end
    exp_busy = 0;
    if (q_size(u) > 0) begin
      e = q_front(u);
      exp_busy = (e.acc <= cyc && cyc < e.due) ? 1 : 0;
    end
    check($sformatf("u%0d_busy", u), int'(get_busy(u)), exp_busy);
    check($sformatf("u%0d_busy_done_excl", u), int'(get_busy(u) & get_done(u)), 0);
  endtask

  // Monitor: compares both units against the scoreboard every negedge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) mon(u);
  end

  initial begin
    int gap;
    rst = 1'b1;
    st0 = 1'b0; a0 = 8'd0; b0 = 8'd0; ci0 = 1'b0;
    st1 = 1'b0; a1 = 2'd0; b1 = 2'd0; ci1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy0), 0);
    check("reset_done", int'(done0), 0);
    check("reset_sum_carry", int'({carry0, sum0}), 0);

    issue(0, 100, 27, 0, 1'b1);
    wait_done(0);
    repeat (3) @(negedge clk);

    @(negedge clk);
    issue(0, 8'hFF, 8'h01, 0, 1'b1);
    wait_done(0);
    issue(0, 8'hA5, 8'h5A, 1, 1'b1);
    wait_done(0);
    repeat (2) @(negedge clk);

    issue(0, 8'h0F, 8'h01, 0, 1'b1);
    repeat (2) @(negedge clk);
    issue(0, 8'hFF, 8'hFF, 0, 1'b0);
    wait_done(0);
    repeat (4) @(negedge clk);

    issue(0, 8'hC3, 8'h3C, 1, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy0), 0);
    check("async_rst_done", int'(done0), 0);
    check("async_rst_sum_carry", int'({carry0, sum0}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(0, 3, 4, 1, 1'b1);
    wait_done(0);
    check("fresh_sum", int'(sum0), 8);

    for (int u = 0; u < 2; u++) begin
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        issue(u, $urandom_range(0, (u == 0) ? 255 : 3), $urandom_range(0, (u == 0) ? 255 : 3),
              $urandom_range(0, 1), 1'b1);
        wait_done(u);
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
      end
    end

    repeat (12) @(negedge clk);
    check("drain_u0", q0.size(), 0);
    check("drain_u1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
